// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-block instruction cache responder.
// Hits return in the same cycle; a miss issues one memory read and fills the frame.
module icache_frame #(
    parameter int TAGW = 26
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            we,
    input  logic [TAGW-1:0] wtag,
    input  logic [31:0]     wdata,
    output logic            valid,
    output logic [TAGW-1:0] tag,
    output logic [31:0]     data
);
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (we) begin
            valid <= 1'b1;
            tag   <= wtag;
            data  <= wdata;
        end
    end
endmodule

module icache_responder #(
    parameter  int NSETS = 16,
    localparam int IDXW  = $clog2(NSETS),
    localparam int TAGW  = 30 - IDXW
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    typedef enum logic {IDLE, FETCH} state_t;

    state_t                       state;
    logic [29:0]                  missaddr;
    logic [IDXW-1:0]              idx, missidx;
    logic [TAGW-1:0]              atag, misstag;
    logic                         hit, fill_we;
    logic                         unused_offset;
    logic [NSETS-1:0]             frame_valid;
    logic [NSETS-1:0][TAGW-1:0]   frame_tag;
    logic [NSETS-1:0][31:0]       frame_data;

    // Byte offset never selects anything: the block is one word.
    assign unused_offset = ^imemaddr[1:0];

    assign idx     = imemaddr[IDXW+1:2];
    assign atag    = imemaddr[31:IDXW+2];
    assign missidx = missaddr[IDXW-1:0];
    assign misstag = missaddr[29:IDXW];

    assign hit      = (state == IDLE) && imemREN && frame_valid[idx]
                      && (frame_tag[idx] == atag);
    assign ihit     = hit;
    assign imemload = hit ? frame_data[idx] : 32'h0;
    assign iaddr    = {missaddr, 2'b00};
    assign fill_we  = (state == FETCH) && !iwait;

    for (genvar i = 0; i < NSETS; i++) begin : g_frame
        icache_frame #(.TAGW(TAGW)) u_frame (
            .CLK   (CLK),
            .nRST  (nRST),
            .we    (fill_we && (missidx == IDXW'(i))),
            .wtag  (misstag),
            .wdata (iload),
            .valid (frame_valid[i]),
            .tag   (frame_tag[i]),
            .data  (frame_data[i])
        );
    end

    // The fetch always runs to completion on the latched address; the
    // requester may move on or withdraw without aborting it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            missaddr <= '0;
            iREN     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !hit) begin
                        missaddr <= imemaddr[31:2];
                        iREN     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        iREN  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: cold miss, wait states, eviction,
// withdrawn request, reset during fetch and unaligned aliasing.
module tb_icache_responder;
    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks   = 0;
    int failures = 0;

    icache_responder #(.NSETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
        #1 nRST = 1'b0;
        #10;
        chk("rst_ihit",     {31'h0, ihit}, 32'h0);
        chk("rst_imemload", imemload,      32'h0);
        chk("rst_iREN",     {31'h0, iREN}, 32'h0);
        chk("rst_iaddr",    iaddr,         32'h0);
        nRST = 1'b1;
        tick();

        // Cold miss, memory ready at once
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; iload = 32'h8C220004;
        #1;
        chk("cold_c0_ihit", {31'h0, ihit}, 32'h0);
        chk("cold_c0_iREN", {31'h0, iREN}, 32'h0);
        tick();
        chk("cold_c1_iREN",  {31'h0, iREN}, 32'h1);
        chk("cold_c1_iaddr", iaddr,         32'h40);
        chk("cold_c1_ihit",  {31'h0, ihit}, 32'h0);
        tick();
        chk("cold_c2_ihit", {31'h0, ihit}, 32'h1);
        chk("cold_c2_data", imemload,      32'h8C220004);
        chk("cold_c2_iREN", {31'h0, iREN}, 32'h0);

        // Miss with three wait cycles
        imemaddr = 32'h44; iwait = 1'b1; iload = 32'h0;
        #1;
        chk("wait_c0_ihit", {31'h0, ihit}, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("wait_iREN",  {31'h0, iREN}, 32'h1);
            chk("wait_iaddr", iaddr,         32'h44);
            chk("wait_ihit",  {31'h0, ihit}, 32'h0);
            tick();
        end
        iwait = 1'b0; iload = 32'h24010005;
        #1;
        chk("wait_done_iREN",  {31'h0, iREN}, 32'h1);
        chk("wait_done_iaddr", iaddr,         32'h44);
        chk("wait_done_ihit",  {31'h0, ihit}, 32'h0);
        tick();
        chk("wait_hit",      {31'h0, ihit}, 32'h1);
        chk("wait_hit_data", imemload,      32'h24010005);
        imemaddr = 32'h40;
        #1;
        chk("idx0_still_hit", imemload, 32'h8C220004);

        // Conflict eviction on index 4
        imemaddr = 32'h10; iload = 32'h11111111;
        #1;
        chk("evict_a_miss", {31'h0, ihit}, 32'h0);
        tick(); tick();
        chk("evict_a_hit", imemload, 32'h11111111);
        imemaddr = 32'h50; iload = 32'h22222222;
        #1;
        chk("evict_b_miss", {31'h0, ihit}, 32'h0);
        tick();
        chk("evict_b_iaddr", iaddr, 32'h50);
        tick();
        chk("evict_b_hit", imemload, 32'h22222222);
        imemaddr = 32'h10; iload = 32'h11111111;
        #1;
        chk("evict_a_remiss", {31'h0, ihit}, 32'h0);
        tick();
        chk("evict_a_iREN",  {31'h0, iREN}, 32'h1);
        chk("evict_a_iaddr", iaddr,         32'h10);
        tick();
        chk("evict_a_rehit", imemload, 32'h11111111);

        // Request withdrawn and address changed during FETCH
        imemaddr = 32'h80; iwait = 1'b1; iload = 32'h0;
        #1;
        chk("wd_miss", {31'h0, ihit}, 32'h0);
        tick();
        imemREN = 1'b0; imemaddr = 32'h200;
        #1;
        chk("wd_iREN",  {31'h0, iREN}, 32'h1);
        chk("wd_iaddr", iaddr,         32'h80);
        tick();
        iwait = 1'b0; iload = 32'hDEADBEEF;
        #1;
        chk("wd_done_ihit", {31'h0, ihit}, 32'h0);
        tick();
        iwait = 1'b1;
        #1;
        chk("wd_idle_ihit", {31'h0, ihit}, 32'h0);
        chk("wd_idle_load", imemload,      32'h0);
        chk("wd_idle_iREN", {31'h0, iREN}, 32'h0);
        tick();
        imemREN = 1'b1; imemaddr = 32'h80;
        #1;
        chk("wd_rehit",      {31'h0, ihit}, 32'h1);
        chk("wd_rehit_data", imemload,      32'hDEADBEEF);
        chk("wd_rehit_iREN", {31'h0, iREN}, 32'h0);

        // Reset during FETCH on the last index
        imemaddr = 32'h3C; iwait = 1'b1;
        #1;
        chk("rf_miss", {31'h0, ihit}, 32'h0);
        tick();
        chk("rf_iREN",  {31'h0, iREN}, 32'h1);
        chk("rf_iaddr", iaddr,         32'h3C);
        iload = 32'h55555555;
        nRST = 1'b0;
        #1;
        chk("rf_async_iREN",  {31'h0, iREN}, 32'h0);
        chk("rf_async_iaddr", iaddr,         32'h0);
        @(posedge CLK);
        #3 nRST = 1'b1;
        #1;
        chk("rf_post_miss", {31'h0, ihit}, 32'h0);
        chk("rf_post_iREN", {31'h0, iREN}, 32'h0);
        imemaddr = 32'h80;
        #1;
        chk("rf_cleared_80", {31'h0, ihit}, 32'h0);
        imemaddr = 32'h3C;
        tick();
        chk("rf_refetch_iaddr", iaddr, 32'h3C);
        iwait = 1'b0; iload = 32'hCAFEF00D;
        tick();
        chk("rf_hit",      {31'h0, ihit}, 32'h1);
        chk("rf_hit_data", imemload,      32'hCAFEF00D);

        // Unaligned alias of a filled word
        imemaddr = 32'h100; iload = 32'h0BADC0DE;
        #1;
        chk("ua_miss", {31'h0, ihit}, 32'h0);
        tick(); tick();
        chk("ua_fill_hit", imemload, 32'h0BADC0DE);
        imemaddr = 32'h103;
        #1;
        chk("ua_alias_hit",  {31'h0, ihit}, 32'h1);
        chk("ua_alias_data", imemload,      32'h0BADC0DE);
        tick();
        chk("ua_no_mem",   {31'h0, iREN}, 32'h0);
        chk("ua_still_hit", {31'h0, ihit}, 32'h1);
        imemREN = 1'b0;
        #1;
        chk("ua_ren0_ihit", {31'h0, ihit}, 32'h0);
        chk("ua_ren0_load", imemload,      32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
